// File: rtl/exe_stage.sv
// Execute stage: latches the ID bus, computes the ALU result, issues the data SRAM request.
// Optional iterative radix-2 divider compiled in with `define EXE_DIV_EN.
module exe_stage (
  input  logic         clk,
  input  logic         reset,
  output logic         exe_allow_in,
  input  logic         id_to_exe_valid,
  input  logic         mem_allow_in,
  output logic         exe_to_mem_valid,
  input  logic [154:0] id_to_exe_bus,
  output logic [107:0] exe_to_mem_bus,
  output logic [39:0]  exe_to_id_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

  typedef struct packed {
    logic [31:0] pc;
    logic [11:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic        res_from_mem;
    logic        reg_we;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [4:0]  reg_waddr;
    logic        div_en;
    logic        div_signed;
    logic        div_rem;
  } id_bus_t;

  typedef enum int unsigned {
    OP_ADD = 0, OP_SUB = 1, OP_SLT = 2, OP_SLTU = 3, OP_AND = 4, OP_NOR = 5,
    OP_OR = 6, OP_XOR = 7, OP_SLL = 8, OP_SRL = 9, OP_SRA = 10, OP_LUI = 11
  } alu_bit_e;

  logic    exe_valid_q, exe_valid_d;
  id_bus_t bus_q, bus_d;
  logic    exe_ready_go;
  logic    handoff;
  logic [31:0] alu_out;
  logic [31:0] alu_result;

  // ---------------- handshake and instruction register ----------------
  assign exe_allow_in     = !exe_valid_q || (exe_ready_go && mem_allow_in);
  assign exe_to_mem_valid = exe_valid_q && exe_ready_go;
  assign handoff          = exe_to_mem_valid && mem_allow_in;

  always_comb begin
    exe_valid_d = exe_valid_q;
    bus_d       = bus_q;
    if (exe_allow_in) exe_valid_d = id_to_exe_valid;
    if (exe_allow_in && id_to_exe_valid) bus_d = id_bus_t'(id_to_exe_bus);
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge value of its peers.
  always_ff @(posedge clk) begin
    if (reset) exe_valid_q <= 1'b0;
    else       exe_valid_q <= exe_valid_d;
  end

  // NOTE: datapath registers carry no reset; they are qualified by a valid bit or FSM state.
  always_ff @(posedge clk) begin
    bus_q <= bus_d;
  end

  // ---------------- ALU: one-hot op, results OR-ed together ----------------
  logic [31:0] sum, diff;
  logic        lt_signed, lt_unsigned;
  logic [4:0]  shamt;

  assign sum         = bus_q.src1 + bus_q.src2;
  assign diff        = bus_q.src1 - bus_q.src2;
  assign lt_signed   = $signed(bus_q.src1) < $signed(bus_q.src2);
  assign lt_unsigned = bus_q.src1 < bus_q.src2;
  assign shamt       = bus_q.src2[4:0];

  always_comb begin
    alu_out = '0;
    if (bus_q.alu_op[OP_ADD])  alu_out = alu_out | sum;
    if (bus_q.alu_op[OP_SUB])  alu_out = alu_out | diff;
    if (bus_q.alu_op[OP_SLT])  alu_out = alu_out | {31'd0, lt_signed};
    if (bus_q.alu_op[OP_SLTU]) alu_out = alu_out | {31'd0, lt_unsigned};
    if (bus_q.alu_op[OP_AND])  alu_out = alu_out | (bus_q.src1 & bus_q.src2);
    if (bus_q.alu_op[OP_NOR])  alu_out = alu_out | ~(bus_q.src1 | bus_q.src2);
    if (bus_q.alu_op[OP_OR])   alu_out = alu_out | (bus_q.src1 | bus_q.src2);
    if (bus_q.alu_op[OP_XOR])  alu_out = alu_out | (bus_q.src1 ^ bus_q.src2);
    if (bus_q.alu_op[OP_SLL])  alu_out = alu_out | (bus_q.src1 << shamt);
    if (bus_q.alu_op[OP_SRL])  alu_out = alu_out | (bus_q.src1 >> shamt);
    if (bus_q.alu_op[OP_SRA])  alu_out = alu_out | 32'($signed(bus_q.src1) >>> shamt);
    if (bus_q.alu_op[OP_LUI])  alu_out = alu_out | bus_q.src2;
  end

`ifdef EXE_DIV_EN
  // ---------------- iterative restoring divider ----------------
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  div_state_e  div_state_q, div_state_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsor_q, dsor_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dbz_q, dbz_d;
  logic [32:0] shifted, trial;
  logic        fits;
  logic [31:0] quot_out, rem_out, div_result;
  logic        unused_trial_msb;

  assign shifted          = {rem_q, quo_q[31]};
  assign trial            = shifted - {1'b0, dsor_q};
  assign fits             = shifted >= {1'b0, dsor_q};
  assign unused_trial_msb = trial[32];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dsor_d      = dsor_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dbz_d       = dbz_q;
    case (div_state_q)
      DIV_IDLE: begin
        if (exe_valid_q && bus_q.div_en) begin
          div_state_d = DIV_BUSY;
          div_cnt_d   = '0;
          rem_d       = '0;
          quo_d       = (bus_q.div_signed && bus_q.src1[31]) ? -bus_q.src1 : bus_q.src1;
          dsor_d      = (bus_q.div_signed && bus_q.src2[31]) ? -bus_q.src2 : bus_q.src2;
          q_neg_d     = bus_q.div_signed && (bus_q.src1[31] ^ bus_q.src2[31]);
          r_neg_d     = bus_q.div_signed && bus_q.src1[31];
          dbz_d       = (bus_q.src2 == '0);
        end
      end
      DIV_BUSY: begin
        // Dividend bits shift out of quo while quotient bits shift in.
        rem_d     = fits ? trial[31:0] : shifted[31:0];
        quo_d     = {quo_q[30:0], fits};
        div_cnt_d = div_cnt_q + 6'd1;
        if (div_cnt_q == 6'd31) div_state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (handoff) div_state_d = DIV_IDLE;
      end
      default: div_state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
    end else begin
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    rem_q   <= rem_d;
    quo_q   <= quo_d;
    dsor_q  <= dsor_d;
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
    dbz_q   <= dbz_d;
  end

  // Divide by zero yields all-ones quotient; the remainder path already equals src1.
  assign quot_out     = dbz_q ? 32'hFFFF_FFFF : (q_neg_q ? -quo_q : quo_q);
  assign rem_out      = r_neg_q ? -rem_q : rem_q;
  assign div_result   = bus_q.div_rem ? rem_out : quot_out;
  assign alu_result   = bus_q.div_en ? div_result : alu_out;
  assign exe_ready_go = !(exe_valid_q && bus_q.div_en && (div_state_q != DIV_DONE));
`else
  logic unused_div_fields;

  assign unused_div_fields = ^{bus_q.div_en, bus_q.div_signed, bus_q.div_rem};
  assign alu_result        = alu_out;
  assign exe_ready_go      = 1'b1;
`endif

  // ---------------- outputs ----------------
  assign data_sram_en    = exe_valid_q && bus_q.mem_en && exe_ready_go && mem_allow_in;
  assign data_sram_we    = data_sram_en ? bus_q.mem_we : 4'd0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = bus_q.rkd_value;

  assign exe_to_mem_bus = {bus_q.pc, bus_q.rkd_value, alu_result, bus_q.res_from_mem,
                           bus_q.reg_we, bus_q.mem_en, bus_q.mem_we, bus_q.reg_waddr};
  assign exe_to_id_bus  = {exe_valid_q, bus_q.reg_we, bus_q.reg_waddr, alu_result,
                           bus_q.res_from_mem};

endmodule
